// File: rtl/multdiv_pkg.sv
// Shared types and defaults for the iterative multiply/divide controller.
// State encoding is fixed so the datapath debug taps can decode it directly.
package multdiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_CYCLES = 32;
    localparam int DEF_CNT_W  = 6;

endpackage

// File: rtl/multdiv_iter_counter.sv
// Iteration counter for the multdiv controller: enable, sync clear, async reset,
// saturating at CYCLES-1 and flagging that terminal count.
module multdiv_iter_counter
    import multdiv_pkg::*;
#(
    parameter int CYCLES = DEF_CYCLES,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             sclr,
    input  logic             en,
    output logic [CNT_W-1:0] iter,
    output logic             tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

    // Hold at the terminal count so iter still reads CYCLES-1 in DONE.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            iter <= '0;
        end else if (sclr) begin
            iter <= '0;
        end else if (en && !tc) begin
            iter <= iter + CNT_W'(1);
        end
    end

    assign tc = (iter == LAST);

endmodule

// File: rtl/multdiv_ctrl.sv
// Control FSM for the iterative multiply/divide datapath: sequences operand load,
// CYCLES step iterations and a one-cycle result/exception report.
module multdiv_ctrl
    import multdiv_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int CYCLES = WIDTH,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             ctrl_mult,
    input  logic             ctrl_div,
    input  logic             divisor_zero,
    input  logic             overflow_in,
    output logic             busy,
    output logic             op_is_div,
    output logic             load_en,
    output logic             acc_clr,
    output logic             step_en,
    output logic [CNT_W-1:0] iter,
    output logic             result_rdy,
    output logic             exception
);

    if (CYCLES < 1 || (64'd1 << CNT_W) <= 64'(CYCLES)) begin : g_param_chk
        $error("multdiv_ctrl: CYCLES must be >= 1 and fit in CNT_W bits");
    end

    state_t state, state_nxt;
    logic   start;
    logic   dz_abort;
    logic   dz_flag;
    logic   tc;

    assign start = ctrl_mult | ctrl_div;

    // divisor_zero is only valid once the datapath has latched the operands,
    // so the abort is decided on the first RUN cycle rather than in LOAD.
    assign dz_abort = (state == ST_RUN) && (iter == '0) && op_is_div && divisor_zero;

    multdiv_iter_counter #(
        .CYCLES (CYCLES),
        .CNT_W  (CNT_W)
    ) u_iter (
        .clk  (clk),
        .clr  (clr),
        .sclr (start),
        .en   (step_en),
        .iter (iter),
        .tc   (tc)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= ST_IDLE;
            op_is_div <= 1'b0;
            dz_flag   <= 1'b0;
        end else begin
            state   <= state_nxt;
            dz_flag <= dz_abort;
            if (start) begin
                op_is_div <= ctrl_div & ~ctrl_mult;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        busy       = 1'b0;
        load_en    = 1'b0;
        acc_clr    = 1'b0;
        step_en    = 1'b0;
        result_rdy = 1'b0;
        exception  = 1'b0;

        case (state)
            ST_IDLE: begin
                state_nxt = ST_IDLE;
            end
            ST_LOAD: begin
                busy      = 1'b1;
                load_en   = 1'b1;
                acc_clr   = 1'b1;
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                busy    = 1'b1;
                step_en = ~dz_abort;
                if (dz_abort || tc) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                result_rdy = 1'b1;
                exception  = op_is_div ? dz_flag : overflow_in;
                state_nxt  = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // A new start abandons whatever is in flight, including DONE.
        if (start) begin
            state_nxt = ST_LOAD;
        end
    end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Bench for multdiv_ctrl: operation-level reference model checked every cycle,
// directed latency/exception scenarios and a randomized start/reset soak.
module tb_multdiv_ctrl;

    localparam int CYCLES = 32;
    localparam int CNT_W  = 6;

    logic             clk = 1'b0;
    logic             clr = 1'b1;
    logic             ctrl_mult = 1'b0;
    logic             ctrl_div = 1'b0;
    logic             divisor_zero = 1'b0;
    logic             overflow_in = 1'b0;
    logic             busy, op_is_div, load_en, acc_clr, step_en, result_rdy, exception;
    logic [CNT_W-1:0] iter;

    int nvec  = 0;
    int nfail = 0;
    int cyc   = 0;

    multdiv_ctrl #(
        .WIDTH  (32),
        .CYCLES (CYCLES),
        .CNT_W  (CNT_W)
    ) dut (
        .clk          (clk),
        .clr          (clr),
        .ctrl_mult    (ctrl_mult),
        .ctrl_div     (ctrl_div),
        .divisor_zero (divisor_zero),
        .overflow_in  (overflow_in),
        .busy         (busy),
        .op_is_div    (op_is_div),
        .load_en      (load_en),
        .acc_clr      (acc_clr),
        .step_en      (step_en),
        .iter         (iter),
        .result_rdy   (result_rdy),
        .exception    (exception)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Operation-level model: m_age counts cycles since the accepted start
    // (1 = operand load), an aborted divide completes at age 3, a normal op at CYCLES+2.
    bit m_active = 1'b0;
    int m_age    = 0;
    bit m_div    = 1'b0;
    bit m_abort  = 1'b0;
    int m_iter   = 0;

    function automatic bit m_done();
        return m_abort ? (m_age == 3) : (m_age == CYCLES + 2);
    endfunction

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            m_active <= 1'b0;
            m_age    <= 0;
            m_div    <= 1'b0;
            m_abort  <= 1'b0;
            m_iter   <= 0;
        end else if (ctrl_mult || ctrl_div) begin
            m_active <= 1'b1;
            m_age    <= 1;
            m_div    <= ctrl_div && !ctrl_mult;
            m_abort  <= 1'b0;
            m_iter   <= 0;
        end else if (m_active) begin
            if (m_done()) begin
                m_active <= 1'b0;
            end else if (m_age == 2 && m_div && divisor_zero) begin
                m_abort <= 1'b1;
                m_age   <= 3;
            end else begin
                m_age <= m_age + 1;
                if (m_age + 1 <= CYCLES + 1) m_iter <= m_age - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!clr) begin
            bit e_busy, e_load, e_step, e_rdy, e_exc;
            int e_iter;
            e_busy = 0; e_load = 0; e_step = 0; e_rdy = 0; e_exc = 0;
            e_iter = m_iter;
            if (m_active) begin
                if (m_age == 1) begin
                    e_busy = 1; e_load = 1; e_iter = 0;
                end else if (m_done()) begin
                    e_rdy = 1;
                    e_exc = m_div ? m_abort : overflow_in;
                end else begin
                    e_busy = 1;
                    e_step = !(m_age == 2 && m_div && divisor_zero);
                    e_iter = m_age - 2;
                end
            end
            check("busy",       int'(busy),       int'(e_busy));
            check("op_is_div",  int'(op_is_div),  int'(m_div));
            check("load_en",    int'(load_en),    int'(e_load));
            check("acc_clr",    int'(acc_clr),    int'(e_load));
            check("step_en",    int'(step_en),    int'(e_step));
            check("iter",       int'(iter),       e_iter);
            check("result_rdy", int'(result_rdy), int'(e_rdy));
            check("exception",  int'(exception),  int'(e_exc));
        end
    end

    task automatic start_op(input bit m, input bit d, output int e);
        @(posedge clk);
        #1 ctrl_mult = m; ctrl_div = d;
        @(posedge clk);
        #1 ctrl_mult = 0; ctrl_div = 0;
        e = cyc;
    endtask

    // Returns the 1-based cycle (relative to start edge e) of the first result_rdy.
    task automatic wait_rdy(input int e, output int lat, output int steps);
        lat = -1;
        steps = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (step_en) steps++;
            if (result_rdy) begin
                lat = cyc - e + 1;
                return;
            end
        end
    endtask

    initial begin
        int e, lat, steps, rdy_cnt;

        repeat (2) @(posedge clk);
        #1 clr = 0;
        repeat (6) @(negedge clk);
        check("idle_busy", int'(busy), 0);
        check("idle_rdy",  int'(result_rdy), 0);

        // Multiply, no overflow
        start_op(1, 0, e);
        wait_rdy(e, lat, steps);
        check("mult_latency", lat, 34);
        check("mult_steps", steps, 32);
        check("mult_exc", int'(exception), 0);
        check("mult_iter_done", int'(iter), 31);
        @(negedge clk);
        check("mult_rdy_pulse", int'(result_rdy), 0);

        // Divide by zero: early abort
        divisor_zero = 1;
        start_op(0, 1, e);
        wait_rdy(e, lat, steps);
        check("dz_latency", lat, 3);
        check("dz_steps", steps, 0);
        check("dz_exc", int'(exception), 1);
        check("dz_busy", int'(busy), 0);
        divisor_zero = 0;

        // Multiply overflow
        overflow_in = 1;
        start_op(1, 0, e);
        wait_rdy(e, lat, steps);
        check("ovf_latency", lat, 34);
        check("ovf_exc", int'(exception), 1);
        @(negedge clk);
        check("ovf_exc_after", int'(exception), 0);
        overflow_in = 0;

        // Normal divide
        start_op(0, 1, e);
        wait_rdy(e, lat, steps);
        check("div_latency", lat, 34);
        check("div_exc", int'(exception), 0);
        check("div_opdiv", int'(op_is_div), 1);

        // Restart: mult at edge 0, div at edge 10
        start_op(1, 0, e);
        repeat (9) @(posedge clk);
        #1 ctrl_div = 1;
        @(posedge clk);
        #1 ctrl_div = 0;
        @(negedge clk);
        check("rst_load", int'(load_en), 1);
        check("rst_opdiv", int'(op_is_div), 1);
        check("rst_iter", int'(iter), 0);
        wait_rdy(e, lat, steps);
        check("restart_latency", lat, 44);

        // Simultaneous pulses, then async reset mid-op
        start_op(1, 1, e);
        @(negedge clk);
        check("both_opdiv", int'(op_is_div), 0);
        check("both_load", int'(load_en), 1);
        repeat (19) @(posedge clk);
        #2 clr = 1;
        #1;
        check("aclr_busy", int'(busy), 0);
        check("aclr_step", int'(step_en), 0);
        check("aclr_iter", int'(iter), 0);
        check("aclr_rdy", int'(result_rdy), 0);
        #1 clr = 0;
        rdy_cnt = 0;
        repeat (60) begin
            @(negedge clk);
            if (result_rdy) rdy_cnt++;
        end
        check("aclr_no_result", rdy_cnt, 0);

        // Randomized soak
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #1;
            ctrl_mult    = ($urandom_range(0, 39) == 0);
            ctrl_div     = ($urandom_range(0, 39) == 0);
            divisor_zero = ($urandom_range(0, 3) == 0);
            overflow_in  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 499) == 0) begin
                clr = 1;
                #2 clr = 0;
            end
        end
        #1 ctrl_mult = 0; ctrl_div = 0;
        repeat (40) @(posedge clk);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
